// File: rtl/mcpu_pkg.sv
// mcpu_pkg: widths, opcode constants and fetch FSM states shared across the MCPU
package mcpu_pkg;

    localparam int WORD_SIZE    = 16;
    localparam int OPERAND_SIZE = 4;
    localparam int ADDR_SIZE    = 8;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_LDI = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_LD  = 4'h9;
    localparam logic [3:0] OP_ST  = 4'hA;
    localparam logic [3:0] OP_BR  = 4'hB;

    typedef enum logic [1:0] {S_RUN, S_HOLD, S_FLUSH} fetch_state_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op inside {OP_NOP, OP_ADD, OP_SUB, OP_LDI, OP_AND, OP_OR,
                          OP_XOR, OP_SHL, OP_SHR, OP_LD, OP_ST, OP_BR};
    endfunction

endpackage

// File: rtl/mcpu_fetch_fifo.sv
// mcpu_fetch_fifo: two-entry shift FIFO, head always in the first slot
module mcpu_fetch_fifo #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_q, tail_q;
    logic [1:0]       count_q, wr_idx;
    logic             do_push, do_pop;

    assign dout    = head_q;
    assign count   = count_q;
    assign full    = count_q == 2'd2;
    assign empty   = count_q == 2'd0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign wr_idx  = count_q - 2'(do_pop);

    // a pop shifts the tail forward; a push lands in the slot left after that shift
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else begin
            head_q  <= do_push && wr_idx == 2'd0 ? din : do_pop ? tail_q : head_q;
            tail_q  <= do_push && wr_idx == 2'd1 ? din : tail_q;
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/mcpu_fetch_decode.sv
// mcpu_fetch_decode: MCPU fetch stage with 2-entry decode buffer and redirect flush
// Optional illegal-opcode flag built only when MCPU_ILLEGAL_OPCODE_CHECK_EN is defined.
module mcpu_fetch_decode #(
    parameter int WORD_SIZE    = mcpu_pkg::WORD_SIZE,
    parameter int OPERAND_SIZE = mcpu_pkg::OPERAND_SIZE,
    parameter int ADDR_SIZE    = mcpu_pkg::ADDR_SIZE
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    mem_rd,
    output logic [ADDR_SIZE-1:0]    mem_addr,
    input  logic [WORD_SIZE-1:0]    mem_rdata,
    input  logic                    halt,
    input  logic                    br_valid,
    input  logic [ADDR_SIZE-1:0]    br_target,
    output logic                    dec_valid,
    input  logic                    dec_ready,
    output logic [OPERAND_SIZE-1:0] dec_opcode,
    output logic [OPERAND_SIZE-1:0] dec_rd,
    output logic [OPERAND_SIZE-1:0] dec_ra,
    output logic [OPERAND_SIZE-1:0] dec_rb,
    output logic [7:0]              dec_imm,
    output logic [ADDR_SIZE-1:0]    dec_pc,
    output logic                    dec_illegal
);

    import mcpu_pkg::*;

    localparam int EW = WORD_SIZE + ADDR_SIZE;

    fetch_state_e         state_q, state_d;
    logic [ADDR_SIZE-1:0] pc_q, pc_d, rd_pc_q;
    logic                 inflight_q, inflight_d;
    logic                 issue, push, pop;
    logic [2:0]           occ_d;
    logic [EW-1:0]        head;
    logic [WORD_SIZE-1:0] head_word;
    logic                 fifo_full, fifo_empty;
    logic [1:0]           fifo_count;

    mcpu_fetch_fifo #(.WIDTH(EW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (br_valid),
        .din   ({mem_rdata, rd_pc_q}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_word  = head[EW-1 -: WORD_SIZE];
    assign dec_pc     = head[ADDR_SIZE-1:0];
    assign dec_opcode = head_word[WORD_SIZE-1 -: OPERAND_SIZE];
    assign dec_rd     = head_word[WORD_SIZE-OPERAND_SIZE-1 -: OPERAND_SIZE];
    assign dec_ra     = head_word[2*OPERAND_SIZE-1 -: OPERAND_SIZE];
    assign dec_rb     = head_word[OPERAND_SIZE-1:0];
    assign dec_imm    = head_word[7:0];
    assign dec_valid  = !fifo_empty && state_q != S_FLUSH;
    assign mem_rd     = issue;
    assign mem_addr   = pc_q;

`ifdef MCPU_ILLEGAL_OPCODE_CHECK_EN
    assign dec_illegal = dec_valid && !op_is_legal(4'(dec_opcode));
`else
    assign dec_illegal = 1'b0;
`endif

    // next state: a redirect overrides everything; otherwise HOLD once buffer plus in-flight reach two
    always_comb begin
        issue      = state_q == S_RUN && !halt && !reset && !fifo_full;
        push       = inflight_q && !br_valid;
        pop        = dec_valid && dec_ready && !br_valid;
        inflight_d = issue && !br_valid;
        occ_d      = br_valid ? 3'd0 : 3'(fifo_count) + 3'(push) - 3'(pop);
        pc_d       = br_valid ? br_target : pc_q + ADDR_SIZE'(issue);
        state_d    = br_valid ? S_FLUSH
                   : (halt || occ_d + 3'(inflight_d) >= 3'd2) ? S_HOLD : S_RUN;
    end

    // fetch FSM, PC and the address of the read currently in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_RUN;
            pc_q       <= '0;
            rd_pc_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            if (issue) rd_pc_q <= pc_q;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        3'(fifo_count) + 3'(inflight_q) <= 3'd2);
    a_rd_has_room: assert property (@(posedge clk) disable iff (reset)
        mem_rd |-> 3'(fifo_count) + 3'(inflight_q) < 3'd2);

endmodule

// File: tb/tb_mcpu_fetch_decode.sv
// tb_mcpu_fetch_decode: directed stimulus with a queue scoreboard checked by a decode-side monitor
module tb_mcpu_fetch_decode;

`ifdef MCPU_ILLEGAL_OPCODE_CHECK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] word;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b1, halt = 1'b0, br_valid = 1'b0, dec_ready = 1'b0;
    logic [7:0]  br_target = 8'h00;
    logic        mem_rd, dec_valid, dec_illegal;
    logic [7:0]  mem_addr, dec_pc, dec_imm;
    logic [15:0] mem_rdata;
    logic [3:0]  dec_opcode, dec_rd, dec_ra, dec_rb;
    logic [15:0] mem [256];
    exp_t        exp_q [$];
    int          checks = 0, errors = 0, hs = 0;

    mcpu_fetch_decode dut (
        .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .halt(halt), .br_valid(br_valid), .br_target(br_target), .dec_valid(dec_valid),
        .dec_ready(dec_ready), .dec_opcode(dec_opcode), .dec_rd(dec_rd), .dec_ra(dec_ra),
        .dec_rb(dec_rb), .dec_imm(dec_imm), .dec_pc(dec_pc), .dec_illegal(dec_illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_seq(input logic [7:0] start, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc   = start + 8'(i);
            e.word = mem[e.pc];
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_hs(input int target, input string name);
        int k = 0;
        while (hs < target && k < 200) begin
            @(posedge clk);
            k++;
        end
        chk(name, 32'(hs >= target), 1);
    endtask

    task automatic wait_rd(input logic any_addr, input logic [7:0] addr, output logic found);
        int k = 0;
        found = 1'b0;
        while (!found && k < 100) begin
            @(negedge clk);
            found = mem_rd && (any_addr || mem_addr == addr);
            k++;
        end
    endtask

    task automatic redirect(input logic [7:0] target, input int n);
        logic found;
        wait_rd(1'b1, 8'h00, found);
        chk("br_wait_rd", 32'(found), 1);
        @(posedge clk);
        #1 br_valid = 1'b1;
        br_target = target;
        exp_q.delete();
        push_seq(target, n);
        @(posedge clk);
        #1 br_valid = 1'b0;
        @(negedge clk);
        chk("flush_dec_valid", 32'(dec_valid), 0);
        chk("flush_mem_rd", 32'(mem_rd), 0);
        @(negedge clk);
        chk("resume_mem_rd", 32'(mem_rd), 1);
        chk("resume_addr", 32'(mem_addr), 32'(target));
    endtask

    // pop the expected entry on every handshake the DUT will honour at the next edge
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && dec_valid && dec_ready && !br_valid) begin
            hs++;
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("dec_pc", 32'(dec_pc), 32'(e.pc));
                chk("dec_fields", 32'({dec_opcode, dec_rd, dec_ra, dec_rb}), 32'(e.word));
                chk("dec_imm", 32'(dec_imm), 32'(e.word[7:0]));
                chk("dec_illegal", 32'(dec_illegal), 32'(ILL_EN && e.word[15:12] >= 4'hC));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] snap;
        logic        found;
        int          h;
        for (int i = 0; i < 256; i++) mem[i] = {4'(i % 12), 4'(i >> 4), 8'(i) ^ 8'hA5};
        mem[8'h00] = 16'h3A5C;
        mem[8'h05] = 16'hD123;
        mem[8'h13] = 16'h7713;
        mem[8'hFF] = 16'hBEEF;
        dec_ready = 1'b1;
        #2;
        chk("rst_mem_rd", 32'(mem_rd), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_dec_valid", 32'(dec_valid), 0);
        chk("rst_fields", 32'({dec_opcode, dec_rd, dec_ra, dec_rb, dec_imm}), 0);
        chk("rst_dec_pc", 32'(dec_pc), 0);
        chk("rst_dec_illegal", 32'(dec_illegal), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_mem_rd", 32'(mem_rd), 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("midrst_dec_valid0", 32'(dec_valid), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        push_seq(8'h00, 40);
        @(negedge clk);
        chk("c0_mem_rd", 32'(mem_rd), 1);
        chk("c0_mem_addr", 32'(mem_addr), 0);
        @(negedge clk);
        chk("c1_dec_valid", 32'(dec_valid), 0);
        @(negedge clk);
        chk("c2_dec_valid", 32'(dec_valid), 1);
        chk("c2_word", 32'({dec_opcode, dec_rd, dec_ra, dec_rb}), 32'h3A5C);
        @(posedge clk);
        #1 dec_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) begin
                snap = {7'd0, dec_valid, dec_pc, dec_opcode, dec_rd, dec_ra, dec_rb};
                chk("stall_valid", 32'(dec_valid), 1);
                chk("stall_head_pc", 32'(dec_pc), 32'(exp_q[0].pc));
            end else begin
                chk("stall_stable", {7'd0, dec_valid, dec_pc, dec_opcode, dec_rd, dec_ra, dec_rb}, snap);
            end
            if (k >= 2) chk("stall_no_rd", 32'(mem_rd), 0);
        end
        @(posedge clk);
        #1 dec_ready = 1'b1;
        wait_hs(10, "drain_0_to_9");
        redirect(8'h13, 30);
        h = hs;
        wait_hs(h + 3, "after_br_13");
        redirect(8'hFD, 40);
        wait_rd(1'b0, 8'hFF, found);
        chk("fetch_ff_seen", 32'(found), 1);
        wait_rd(1'b1, 8'h00, found);
        chk("fetch_after_ff", 32'(mem_addr), 0);
        wait_hs(h + 8, "after_wrap");
        @(posedge clk);
        #1 halt = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("halt_no_rd", 32'(mem_rd), 0);
        end
        chk("halt_drained", 32'(dec_valid), 0);
        h = hs;
        @(posedge clk);
        #1 halt = 1'b0;
        wait_hs(h + 3, "after_halt");
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
